// File: rtl/rx_deser_align_if.sv
// rx_deser_align_if: serial input / aligned parallel output bundle of the RX deserializer.
// Optional macro RX_BITSLIP_EN adds the manual Slip request line.
interface rx_deser_align_if #(
    parameter int WORD_W = 10
);
    logic              Serial;
`ifdef RX_BITSLIP_EN
    logic              Slip;
`endif
    logic [WORD_W-1:0] RxParallel;
    logic              RxValid;
    logic              RxComma;
    logic              Locked;

`ifdef RX_BITSLIP_EN
    modport master (output Serial, output Slip,
                    input RxParallel, input RxValid, input RxComma, input Locked);
    modport slave  (input Serial, input Slip,
                    output RxParallel, output RxValid, output RxComma, output Locked);
`else
    modport master (output Serial,
                    input RxParallel, input RxValid, input RxComma, input Locked);
    modport slave  (input Serial,
                    output RxParallel, output RxValid, output RxComma, output Locked);
`endif
endinterface

// File: rtl/rx_deser_align.sv
// rx_deser_align: serial-to-parallel deserializer with comma-based word alignment,
// lock qualification over LOCK_CNT aligned commas and loss after LOSS_CNT misaligned ones.
// Optional macro RX_BITSLIP_EN: adds the Slip input (holds the word phase for one bit in
// HUNT/SYNC so the boundary moves one bit later).
module rx_deser_align #(
    parameter int                WORD_W    = 10,
    parameter logic [WORD_W-1:0] COMMA     = 10'b0011111010,
    parameter bit                MSB_FIRST = 1'b0,
    parameter int                LOCK_CNT  = 3,
    parameter int                LOSS_CNT  = 4
) (
    input logic             BitCLK,
    input logic             Reset,
    rx_deser_align_if.slave rx
);
    localparam int PH_W   = $clog2(WORD_W);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(LOSS_CNT + 1);

    localparam logic [PH_W-1:0]   PH_ZERO   = PH_W'(0);
    localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(WORD_W - 1);
    localparam logic [GOOD_W-1:0] GOOD_ZERO = GOOD_W'(0);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_ZERO  = BAD_W'(0);
    localparam logic [BAD_W-1:0]  BAD_ONE   = BAD_W'(1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_CNT - 1);

    // Reverse bit order of a word.
    function automatic logic [WORD_W-1:0] bit_rev(input logic [WORD_W-1:0] v);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < WORD_W; i++) begin
            r[i] = v[WORD_W-1-i];
        end
        return r;
    endfunction

    // COMMA is written first-received-bit-at-MSB; map it into the output word orientation.
    localparam logic [WORD_W-1:0] COMMA_W = (MSB_FIRST != 1'b0) ? COMMA : bit_rev(COMMA);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state_r;
    logic [WORD_W-1:0]   sr_r;
    logic [WORD_W-1:0]   par_r;
    logic [PH_W-1:0]     ph_r;
    logic [GOOD_W-1:0]   good_r;
    logic [BAD_W-1:0]    bad_r;
    logic                valid_r;
    logic                comma_r;
    logic                locked_r;

    logic [WORD_W-1:0]   nw_s;
    logic [PH_W-1:0]     ph_inc_s;
    logic                match_s;
    logic                boundary_s;
    logic                slip_s;

`ifdef RX_BITSLIP_EN
    assign slip_s = rx.Slip;
`else
    assign slip_s = 1'b0;
`endif

    // Next window with the incoming bit, comma match and word-boundary decode.
    always_comb begin
        nw_s = sr_r;
        if (MSB_FIRST != 1'b0) begin
            nw_s = {sr_r[WORD_W-2:0], rx.Serial};
        end else begin
            nw_s = {rx.Serial, sr_r[WORD_W-1:1]};
        end
        match_s    = (nw_s == COMMA_W) || (nw_s == ~COMMA_W);
        boundary_s = (ph_r == PH_LAST);
        if (boundary_s) begin
            ph_inc_s = PH_ZERO;
        end else begin
            ph_inc_s = ph_r + PH_ONE;
        end
    end

    // Shift register, HUNT/SYNC/LOCKED alignment FSM and registered outputs.
    always_ff @(posedge BitCLK) begin
        if (Reset) begin
            sr_r     <= '0;
            par_r    <= '0;
            ph_r     <= PH_ZERO;
            good_r   <= GOOD_ZERO;
            bad_r    <= BAD_ZERO;
            valid_r  <= 1'b0;
            comma_r  <= 1'b0;
            locked_r <= 1'b0;
            state_r  <= ST_HUNT;
        end else begin
            sr_r     <= nw_s;
            valid_r  <= 1'b0;
            comma_r  <= 1'b0;
            locked_r <= (state_r == ST_LOCKED);
            case (state_r)
                ST_HUNT: begin
                    if (match_s) begin
                        par_r   <= nw_s;
                        valid_r <= 1'b1;
                        comma_r <= 1'b1;
                        ph_r    <= PH_ZERO;
                        good_r  <= GOOD_ONE;
                        bad_r   <= BAD_ZERO;
                        state_r <= (LOCK_CNT == 1) ? ST_LOCKED : ST_SYNC;
                    end else if (slip_s) begin
                        ph_r <= ph_r;
                    end else begin
                        ph_r <= ph_inc_s;
                    end
                end
                ST_SYNC: begin
                    if (match_s && boundary_s) begin
                        // A comma exactly on the boundary is always the aligned case.
                        par_r   <= nw_s;
                        valid_r <= 1'b1;
                        comma_r <= 1'b1;
                        ph_r    <= PH_ZERO;
                        if (good_r >= GOOD_LAST) begin
                            good_r  <= GOOD_MAX;
                            bad_r   <= BAD_ZERO;
                            state_r <= ST_LOCKED;
                        end else begin
                            good_r <= good_r + GOOD_ONE;
                        end
                    end else if (match_s) begin
                        // Off-boundary comma: realign onto it and restart qualification.
                        par_r   <= nw_s;
                        valid_r <= 1'b1;
                        comma_r <= 1'b1;
                        ph_r    <= PH_ZERO;
                        good_r  <= GOOD_ONE;
                    end else if (slip_s) begin
                        ph_r <= ph_r;
                    end else if (boundary_s) begin
                        par_r   <= nw_s;
                        valid_r <= 1'b1;
                        ph_r    <= PH_ZERO;
                    end else begin
                        ph_r <= ph_inc_s;
                    end
                end
                ST_LOCKED: begin
                    if (boundary_s) begin
                        par_r   <= nw_s;
                        valid_r <= 1'b1;
                        comma_r <= match_s;
                        ph_r    <= PH_ZERO;
                        if (match_s) begin
                            bad_r <= BAD_ZERO;
                        end else begin
                            bad_r <= bad_r;
                        end
                    end else if (match_s) begin
                        // Misaligned comma: keep the phase, count towards loss of lock.
                        if (bad_r >= BAD_LAST) begin
                            state_r <= ST_HUNT;
                            ph_r    <= PH_ZERO;
                            good_r  <= GOOD_ZERO;
                            bad_r   <= BAD_ZERO;
                        end else begin
                            bad_r <= bad_r + BAD_ONE;
                            ph_r  <= ph_inc_s;
                        end
                    end else begin
                        ph_r <= ph_inc_s;
                    end
                end
                default: begin
                    state_r <= ST_HUNT;
                    ph_r    <= PH_ZERO;
                    good_r  <= GOOD_ZERO;
                    bad_r   <= BAD_ZERO;
                end
            endcase
        end
    end

    assign rx.RxParallel = par_r;
    assign rx.RxValid    = valid_r;
    assign rx.RxComma    = comma_r;
    assign rx.Locked     = locked_r;

endmodule

// File: tb/tb_rx_deser_align.sv
// tb_rx_deser_align: randomized + directed bench for rx_deser_align with a bit-history
// reference model. Two DUTs (LSB-first and MSB-first) share the serial stream.
module tb_rx_deser_align;
    localparam int         W     = 10;
    localparam int         LOCK  = 3;
    localparam int         LOSS  = 4;
    localparam logic [9:0] K_NEG = 10'b0011111010;
    localparam logic [9:0] K_POS = 10'b1100000101;
    localparam logic [9:0] ALT   = 10'b1010101010;
`ifdef RX_BITSLIP_EN
    localparam bit SLIP_EN = 1'b1;
`else
    localparam bit SLIP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser = 1'b0;
    logic slp = 1'b0;
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rx_deser_align_if #(.WORD_W(W)) rx0 ();
    rx_deser_align_if #(.WORD_W(W)) rx1 ();

    assign rx0.Serial = ser;
    assign rx1.Serial = ser;
`ifdef RX_BITSLIP_EN
    assign rx0.Slip = slp;
    assign rx1.Slip = slp;
`endif

    rx_deser_align #(.WORD_W(W), .MSB_FIRST(1'b0)) u_dut0 (.BitCLK(clk), .Reset(rst), .rx(rx0));
    rx_deser_align #(.WORD_W(W), .MSB_FIRST(1'b1)) u_dut1 (.BitCLK(clk), .Reset(rst), .rx(rx1));

    // ---------------- reference model ----------------
    // Mode: 0 = hunting, 1 = qualifying, 2 = locked. Word ends are the bit indices
    // congruent to m_anchor modulo W (m_anchor = index of the last realigning comma).
    int         m_mode;
    int         m_n;
    int         m_anchor;
    int         m_good;
    int         m_bad;
    logic [9:0] m_win;       // last W received bits, oldest at MSB
    logic       e_valid;
    logic       e_comma;
    logic       e_locked;
    logic [9:0] e_par_lsb;
    logic [9:0] e_par_msb;

    function automatic logic [9:0] rev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_anchor = 0; m_good = 0; m_bad = 0; m_win = 10'd0;
        e_valid = 1'b0; e_comma = 1'b0; e_locked = 1'b0;
        e_par_lsb = 10'd0; e_par_msb = 10'd0;
    endtask

    task automatic model_emit(input logic c);
        e_valid = 1'b1;
        e_comma = c;
        e_par_msb = m_win;
        e_par_lsb = rev10(m_win);
    endtask

    task automatic model_step(input logic b, input logic s);
        logic hit, bnd, sl;
        int   prev;
        m_win = {m_win[8:0], b};
        hit  = (m_win == K_NEG) || (m_win == K_POS);
        bnd  = ((m_n - m_anchor) % W) == 0;
        sl   = s && SLIP_EN;
        prev = m_mode;
        e_valid = 1'b0;
        e_comma = 1'b0;
        if (m_mode == 0) begin
            if (hit) begin
                model_emit(1'b1);
                m_anchor = m_n; m_good = 1; m_bad = 0;
                m_mode = (LOCK == 1) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (hit && bnd) begin
                model_emit(1'b1);
                m_good++;
                if (m_good >= LOCK) begin m_good = LOCK; m_mode = 2; m_bad = 0; end
            end else if (hit) begin
                model_emit(1'b1);
                m_anchor = m_n; m_good = 1;
            end else if (sl) begin
                m_anchor++;
            end else if (bnd) begin
                model_emit(1'b0);
            end
        end else begin
            if (bnd) begin
                model_emit(hit);
                if (hit) m_bad = 0;
            end else if (hit) begin
                m_bad++;
                if (m_bad >= LOSS) begin m_mode = 0; m_good = 0; m_bad = 0; end
            end
        end
        e_locked = (prev == 2);
        m_n++;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare both DUTs against the model on every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("RxValid0",   {9'd0, rx0.RxValid}, {9'd0, e_valid});
            chk("RxComma0",   {9'd0, rx0.RxComma}, {9'd0, e_comma});
            chk("Locked0",    {9'd0, rx0.Locked},  {9'd0, e_locked});
            chk("RxParallel0", rx0.RxParallel,     e_par_lsb);
            chk("RxValid1",   {9'd0, rx1.RxValid}, {9'd0, e_valid});
            chk("RxComma1",   {9'd0, rx1.RxComma}, {9'd0, e_comma});
            chk("Locked1",    {9'd0, rx1.Locked},  {9'd0, e_locked});
            chk("RxParallel1", rx1.RxParallel,     e_par_msb);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b, input logic s);
        @(negedge clk);
        ser = b;
        slp = s;
        @(posedge clk);
        model_step(b, s);
        #1;
    endtask

    // Sends w[nb-1] first down to w[0]; rnd_slip adds sparse random slip pulses.
    task automatic send_bits(input logic [9:0] w, input int nb, input bit rnd_slip);
        for (int i = nb - 1; i >= 0; i--) begin
            send_bit(w[i], rnd_slip && ($urandom_range(0, 29) == 0));
        end
    endtask

    task automatic do_reset(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            rst = 1'b1;
            ser = i[0];
            slp = 1'b0;
            @(posedge clk);
            model_reset();
            #1;
            chk_en = 1'b1;
        end
        rst = 1'b0;
    endtask

    // Five-bit misaligned comma group: 5 filler + comma + 5 filler keeps the word phase.
    task automatic misaligned_comma(input logic [9:0] k);
        send_bits(ALT, 5, 1'b0);
        send_bits(k, 10, 1'b0);
        chk("misaligned_no_emit", {9'd0, rx0.RxValid}, 10'd0);
        send_bits(ALT, 5, 1'b0);
    endtask

    initial begin
        model_reset();
        // 1: reset with toggling serial
        do_reset(3);
        chk("reset_par",    rx0.RxParallel, 10'h000);
        chk("reset_valid",  {9'd0, rx0.RxValid}, 10'd0);
        chk("reset_locked", {9'd0, rx0.Locked},  10'd0);

        // 2: 7 random bits, K28.5 RD-, then data
        send_bits(10'($urandom_range(0, 127)), 7, 1'b0);
        send_bits(K_NEG, 10, 1'b0);
        chk("first_comma_valid", {9'd0, rx0.RxValid}, 10'd1);
        chk("first_comma_flag",  {9'd0, rx0.RxComma}, 10'd1);
        chk("first_comma_lsb",   rx0.RxParallel, 10'h17C);
        chk("first_comma_msb",   rx1.RxParallel, 10'h0FA);
        send_bits(ALT, 10, 1'b0);
        chk("data_word_lsb", rx0.RxParallel, 10'h155);
        chk("data_word_flag", {9'd0, rx0.RxComma}, 10'd0);

        // 3: qualify lock with alternating disparity
        send_bits(K_POS, 10, 1'b0);
        send_bits(ALT, 10, 1'b0);
        send_bits(K_NEG, 10, 1'b0);
        chk("third_comma_locked", {9'd0, rx0.Locked}, 10'd0);
        send_bit(1'b1, 1'b0);
        chk("lock_rise", {9'd0, rx0.Locked}, 10'd1);
        send_bits(ALT, 9, 1'b0);

        // 5: loss of lock, with an aligned comma clearing the count in between
        misaligned_comma(K_NEG);
        misaligned_comma(K_POS);
        send_bits(K_NEG, 10, 1'b0);
        misaligned_comma(K_NEG);
        misaligned_comma(K_POS);
        misaligned_comma(K_NEG);
        chk("still_locked", {9'd0, rx0.Locked}, 10'd1);
        send_bits(ALT, 5, 1'b0);
        send_bits(K_POS, 10, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("lock_fall", {9'd0, rx0.Locked}, 10'd0);
        send_bits(ALT, 8, 1'b0);

        // 4: realign in SYNC on a comma 3 bits off the boundary
        do_reset(2);
        send_bits(K_NEG, 10, 1'b0);
        send_bits(ALT, 3, 1'b0);
        send_bits(K_NEG, 10, 1'b0);
        chk("realign_valid", {9'd0, rx0.RxValid}, 10'd1);
        chk("realign_comma", {9'd0, rx0.RxComma}, 10'd1);
        send_bits(ALT, 10, 1'b0);
        chk("realign_data", rx0.RxParallel, 10'h155);
        send_bits(K_POS, 10, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("realign_not_locked", {9'd0, rx0.Locked}, 10'd0);
        send_bits(ALT, 9, 1'b0);

        // 6: slip in HUNT emits nothing; slip in LOCKED is ignored
        do_reset(2);
        for (int w = 0; w < 10; w++) begin
            for (int b = 9; b >= 0; b--) send_bit(ALT[b], (w == 4) && (b == 3));
        end
        chk("hunt_slip_locked", {9'd0, rx0.Locked}, 10'd0);
        send_bits(K_NEG, 10, 1'b0);
        send_bits(ALT, 10, 1'b0);
        send_bits(K_POS, 10, 1'b0);
        send_bits(ALT, 10, 1'b0);
        send_bits(K_NEG, 10, 1'b0);
        for (int b = 9; b >= 0; b--) send_bit(ALT[b], b == 5);
        chk("locked_slip_valid", {9'd0, rx1.RxValid}, 10'd1);
        chk("locked_msb_word",   rx1.RxParallel, 10'h2AA);
        chk("locked_lsb_word",   rx0.RxParallel, 10'h155);
        chk("locked_after_slip", {9'd0, rx1.Locked}, 10'd1);

        // Random words, commas and phase-breaking fillers
        do_reset(2);
        for (int k = 0; k < 400; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                send_bits(($urandom_range(0, 1) == 0) ? K_NEG : K_POS, 10, 1'b1);
            end else if (r < 85) begin
                send_bits(10'($urandom_range(0, 1023)), 10, 1'b1);
            end else begin
                send_bits(10'($urandom_range(0, 1023)), int'($urandom_range(1, 9)), 1'b1);
            end
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
